// File: rtl/hd63701_ram_arbiter.sv
// 128x8 built-in work RAM ($0080-$00FF) shared between the core bus and a host port; the core always wins.
// Optional host wait timeout is enabled by defining HD63701_RAMARB_TMO_EN.
module hd63701_ram_arbiter #(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic        mcu_clx2,
  input  logic        mcu_rst_n,
  input  logic [15:0] mcu_ad,
  input  logic        mcu_wr,
  input  logic [7:0]  mcu_do,
  output logic        en_biram,
  output logic [7:0]  biramd,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [6:0]  host_ad,
  input  logic [7:0]  host_wd,
  output logic        host_ack,
  output logic [7:0]  host_rd,
  output logic        host_err,
  output logic        host_busy
);

  // state   | meaning
  // ST_IDLE | no host transaction; sample host_req
  // ST_WAIT | host op captured, waiting for a cycle the core leaves the RAM alone
  // ST_ACK  | one-cycle completion pulse on host_ack
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t      state, state_nx;
  logic        cap_wr;
  logic [6:0]  cap_ad;
  logic [7:0]  cap_wd;
  logic        host_slot;
  logic [7:0]  mem [0:127];

  if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_bad_tmo
    $error("TMO_CYC must be in 1..255");
  end

  assign en_biram  = (mcu_ad[15:7] == 9'b000000001);
  assign host_slot = (state == ST_WAIT) && !en_biram;
  assign host_ack  = (state == ST_ACK);
  assign host_busy = (state != ST_IDLE);

`ifdef HD63701_RAMARB_TMO_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  logic [7:0] wait_cnt;
  logic       tmo_hit;
  logic       err_q;

  assign tmo_hit  = (state == ST_WAIT) && en_biram && (wait_cnt == TMO_LAST);
  assign host_err = err_q;

  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      if (state == ST_IDLE && host_req)
        wait_cnt <= 8'd0;
      else if (state == ST_WAIT && en_biram && !tmo_hit)
        wait_cnt <= wait_cnt + 8'd1;
      err_q <= tmo_hit;
    end
  end
`else
  assign host_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (host_req) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (!en_biram) state_nx = ST_ACK;
`ifdef HD63701_RAMARB_TMO_EN
        else if (tmo_hit) state_nx = ST_ACK;
`endif
      end
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      state   <= ST_IDLE;
      cap_wr  <= 1'b0;
      cap_ad  <= 7'd0;
      cap_wd  <= 8'd0;
      biramd  <= 8'd0;
      host_rd <= 8'd0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && host_req) begin
        cap_wr <= host_wr;
        cap_ad <= host_ad;
        cap_wd <= host_wd;
      end
      if (host_slot) begin
        if (!cap_wr) host_rd <= mem[cap_ad];
      end else if (!(en_biram && mcu_wr)) begin
        biramd <= mem[mcu_ad[6:0]];
      end
    end
  end

  // RAM contents survive reset; the single port is steered by host_slot.
  always_ff @(posedge mcu_clx2) begin
    if (host_slot) begin
      if (cap_wr) mem[cap_ad] <= cap_wd;
    end else if (en_biram && mcu_wr) begin
      mem[mcu_ad[6:0]] <= mcu_do;
    end
  end

endmodule

// File: tb/tb_hd63701_ram_arbiter.sv
// Self-checking bench for hd63701_ram_arbiter: table of core accesses plus host-port sequences.
module tb_hd63701_ram_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mcu_ad;
  logic        mcu_wr;
  logic [7:0]  mcu_do;
  logic        en_biram;
  logic [7:0]  biramd;
  logic        host_req, host_wr;
  logic [6:0]  host_ad;
  logic [7:0]  host_wd;
  logic        host_ack, host_err, host_busy;
  logic [7:0]  host_rd;

  always #5 clk = ~clk;

  hd63701_ram_arbiter #(.TMO_CYC(TMO)) dut (
    .mcu_clx2(clk), .mcu_rst_n(rst_n), .mcu_ad(mcu_ad), .mcu_wr(mcu_wr), .mcu_do(mcu_do),
    .en_biram(en_biram), .biramd(biramd), .host_req(host_req), .host_wr(host_wr),
    .host_ad(host_ad), .host_wd(host_wd), .host_ack(host_ack), .host_rd(host_rd),
    .host_err(host_err), .host_busy(host_busy)
  );

  typedef struct {
    logic [15:0] ad;
    logic        wr;
    logic [7:0]  d;
    logic        en;
    logic        chk_rd;
    logic [7:0]  rd;
  } vec_t;

  typedef struct {
    logic [7:0] rd;
    logic       err;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [7:0] ram_m [0:127];
  logic [7:0] rd_model;
  vec_t       vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({name, "_rd"}, host_rd, e.rd);
      chk({name, "_err"}, host_err, e.err);
    end
  endtask

  // Host transaction with the core bus already set up; exp_lat counts edges from request to ack.
  task automatic host_op(input logic wr, input logic [6:0] ad, input logic [7:0] wd,
                         input int exp_lat, input string name);
    exp_t e;
    int   lat;
    logic got;
    e.rd  = wr ? rd_model : ram_m[ad];
    e.err = 1'b0;
    sb.push_back(e);
    host_req = 1'b1; host_wr = wr; host_ad = ad; host_wd = wd;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      cyc();
      lat++;
      if (lat == 1) host_req = 1'b0;
      if (host_ack) begin
        got = 1'b1;
        sb_check(name);
      end
    end
    chk({name, "_lat"}, lat, exp_lat);
    if (got) begin
      if (wr) ram_m[ad] = wd;
      else rd_model = ram_m[ad];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, viol;
    logic idle_seen, prev_ack, got;
    int lat;
    exp_t e;

    vt[0]  = '{16'h0080, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00};
    vt[1]  = '{16'h0081, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00};
    vt[2]  = '{16'h00FF, 1'b1, 8'h33, 1'b1, 1'b0, 8'h00};
    vt[3]  = '{16'h00C0, 1'b1, 8'h44, 1'b1, 1'b0, 8'h00};
    vt[4]  = '{16'h1081, 1'b1, 8'h99, 1'b0, 1'b0, 8'h00};
    vt[5]  = '{16'h0080, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11};
    vt[6]  = '{16'h0081, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22};
    vt[7]  = '{16'h00FF, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33};
    vt[8]  = '{16'h00C0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h44};
    vt[9]  = '{16'h0100, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11};
    vt[10] = '{16'h1081, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22};
    vt[11] = '{16'h0082, 1'b1, 8'h55, 1'b1, 1'b1, 8'h22};
    vt[12] = '{16'h0082, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55};
    vt[13] = '{16'h007F, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33};

    for (int i = 0; i < 128; i++) ram_m[i] = 8'hxx;
    rd_model = 8'h00;
    rst_n = 1'b0; mcu_ad = 16'h0000; mcu_wr = 1'b0; mcu_do = 8'h00;
    host_req = 1'b0; host_wr = 1'b0; host_ad = 7'd0; host_wd = 8'd0;
    @(negedge clk); @(negedge clk);
    chk("rst_biramd", biramd, 8'h00);
    chk("rst_host_rd", host_rd, 8'h00);
    chk("rst_ack", host_ack, 0);
    chk("rst_err", host_err, 0);
    chk("rst_busy", host_busy, 0);
    rst_n = 1'b1;

    // core accesses from the table
    for (int i = 0; i < 14; i++) begin
      mcu_ad = vt[i].ad; mcu_wr = vt[i].wr; mcu_do = vt[i].d;
      #1;
      chk($sformatf("vec%0d_en", i), en_biram, vt[i].en);
      cyc();
      if (vt[i].chk_rd) chk($sformatf("vec%0d_biramd", i), biramd, vt[i].rd);
      if (vt[i].wr && vt[i].en) ram_m[vt[i].ad[6:0]] = vt[i].d;
    end
    mcu_wr = 1'b0;

    // host write then read back with the core outside the window
    mcu_ad = 16'hF000;
    host_op(1'b1, 7'h10, 8'hA5, 2, "hw10");
    chk("hw10_rd_keep", host_rd, rd_model);
    cyc();
    host_op(1'b0, 7'h10, 8'h00, 2, "hr10");
    cyc();

    // core write, then host read of the same byte, then core read
    mcu_ad = 16'h0085; mcu_wr = 1'b1; mcu_do = 8'h3C;
    cyc();
    ram_m[7'h05] = 8'h3C;
    mcu_ad = 16'hF000; mcu_wr = 1'b0;
    host_op(1'b0, 7'h05, 8'h00, 2, "hr05");
    cyc();
    mcu_ad = 16'h0085;
    cyc();
    chk("core_rd85", biramd, 8'h3C);

    // core occupies the window for 6 edges while the host reads 0x20
    mcu_ad = 16'hF000;
    host_op(1'b1, 7'h20, 8'h5A, 2, "hw20");
    cyc();
    mcu_ad = 16'h0090;
    e.rd = ram_m[7'h20]; e.err = 1'b0;
    sb.push_back(e);
    host_req = 1'b1; host_wr = 1'b0; host_ad = 7'h20;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      host_req = 1'b0;
      chk($sformatf("blk%0d_ack", k), host_ack, 0);
      chk($sformatf("blk%0d_busy", k), host_busy, 1);
      chk($sformatf("blk%0d_biramd", k), biramd, ram_m[7'h10]);
    end
    mcu_ad = 16'hF000;
    cyc();
    chk("blk_ack", host_ack, 1);
    if (host_ack) sb_check("blk");
    chk("blk_biramd_hold", biramd, ram_m[7'h10]);
    rd_model = ram_m[7'h20];
    cyc();

    // host write to 0x7F while the core sits on $00FF
    mcu_ad = 16'h00FF;
    host_req = 1'b1; host_wr = 1'b1; host_ad = 7'h7F; host_wd = 8'hEE;
`ifdef HD63701_RAMARB_TMO_EN
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      cyc();
      lat++;
      host_req = 1'b0;
      if (host_ack) got = 1'b1;
    end
    chk("tmo_lat", lat, TMO + 1);
    chk("tmo_err", host_err, 1);
    chk("tmo_rd_keep", host_rd, rd_model);
    cyc();
    chk("tmo_err_clr", host_err, 0);
    chk("tmo_ram_keep", biramd, ram_m[7'h7F]);
`else
    for (int k = 1; k <= 10; k++) begin
      cyc();
      host_req = 1'b0;
      chk($sformatf("stall%0d_ack", k), host_ack, 0);
      chk($sformatf("stall%0d_busy", k), host_busy, 1);
    end
    chk("stall_ram_keep", biramd, ram_m[7'h7F]);
    mcu_ad = 16'hF000;
    cyc();
    chk("stall_release_ack", host_ack, 1);
    chk("stall_release_err", host_err, 0);
    ram_m[7'h7F] = 8'hEE;
    cyc();
    mcu_ad = 16'h00FF;
    cyc();
    chk("stall_ram_new", biramd, 8'hEE);
`endif

    // request held high: three back-to-back reads
    mcu_ad = 16'hF000;
    for (int k = 0; k < 3; k++) begin
      e.rd = ram_m[7'h10]; e.err = 1'b0;
      sb.push_back(e);
    end
    host_req = 1'b1; host_wr = 1'b0; host_ad = 7'h10;
    acks = 0; viol = 0; idle_seen = 1'b1; prev_ack = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (host_ack) begin
        if (prev_ack || !idle_seen) viol++;
        acks++;
        sb_check("b2b");
        idle_seen = 1'b0;
        if (acks == 3) host_req = 1'b0;
      end
      if (!host_busy) idle_seen = 1'b1;
      prev_ack = host_ack;
    end
    rd_model = ram_m[7'h10];
    chk("b2b_acks", acks, 3);
    chk("b2b_spacing", viol, 0);

    // reset while a host write is waiting
    mcu_ad = 16'h0090;
    host_req = 1'b1; host_wr = 1'b1; host_ad = 7'h10; host_wd = 8'h77;
    cyc();
    host_req = 1'b0;
    cyc();
    chk("rstw_busy_pre", host_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rstw_ack", host_ack, 0);
    chk("rstw_busy", host_busy, 0);
    chk("rstw_biramd", biramd, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    rd_model = 8'h00;
    cyc();
    chk("rstw_ram_keep", biramd, ram_m[7'h10]);
    chk("rstw_host_rd", host_rd, rd_model);

    // reset during the ack cycle
    mcu_ad = 16'hF000;
    host_req = 1'b1; host_wr = 1'b0; host_ad = 7'h05;
    cyc();
    host_req = 1'b0;
    cyc();
    chk("rsta_ack_pre", host_ack, 1);
    rst_n = 1'b0;
    #1;
    chk("rsta_ack", host_ack, 0);
    chk("rsta_busy", host_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("rsta_ack_post", host_ack, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
